// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART definitions: receiver FSM encodings, default sampling parameters, parity helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_rx_oversampled_pkg;

  localparam int OVS_DEFAULT         = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity bit as the TX path generates it; unused upper data bits must be zero.
  function automatic logic parity_bit(input logic odd_n_even, input logic [7:0] data);
    return odd_n_even ^ (^data);
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Host-side receive bus: received byte, status flags, FIFO strobe and read acknowledge.
// Latency: n/a (wiring only).
// Backpressure: none; the host acknowledges with read_rx_byte, late reads show up as overflow.
interface uart_rx_oversampled_if;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       fifo_write;
  logic       read_rx_byte;

  modport master (
    output rx_byte, rx_rdy, parity_err, framing_err, overflow, fifo_write,
    input  read_rx_byte
  );

  modport slave (
    input  rx_byte, rx_rdy, parity_err, framing_err, overflow, fifo_write,
    output read_rx_byte
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous rx line into the clk domain and flags its falling edges.
// Latency: SYNC_STAGES clk from rx to rxs; fall is combinational from rxs.
// Backpressure: none.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic aresetn,
  input  logic rx,
  output logic rxs,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_prev;

  // Shift the line through the synchronizer; flops reset to the idle-high level so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], rx};
      rx_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rxs  = sync[SYNC_STAGES-1];
  // Edge, not level: a line held low (break) never retriggers a frame.
  assign fall = rx_prev & ~rxs;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: 16x-oversampled deframer for start / 7|8 data / optional parity / stop.
// Latency: rx_rdy and fifo_write rise 1 clk after the baud_en that samples mid stop bit.
// Backpressure: none; a byte arriving while rx_rdy is set overwrites rx_byte and sets overflow.
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int OVS         = OVS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          baud_en,
  input  logic                          rx,
  input  logic                          bit8,
  input  logic                          parity_en,
  input  logic                          odd_n_even,
  uart_rx_oversampled_if.master         host
);

  localparam int            CW       = $clog2(OVS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bitn, bitn_nx;
  logic [7:0]    data, data_nx;
  logic          perr, perr_nx;
  logic          load;
  logic          rxs;
  logic          fall;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .aresetn (aresetn),
    .rx      (rx),
    .rxs     (rxs),
    .fall    (fall)
  );

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state plus counter/shift-register updates; everything but the idle edge
  // detect advances only on baud_en. cnt wraps naturally at OVS-1.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bitn_nx  = bitn;
    data_nx  = data;
    perr_nx  = perr;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          cnt_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        if (baud_en) begin
          if (cnt == CNT_HALF) begin
            cnt_nx = '0;
            if (!rxs) begin
              bitn_nx  = '0;
              data_nx  = '0;
              perr_nx  = 1'b0;
              state_nx = DATA;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      DATA: begin
        if (baud_en) begin
          cnt_nx = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            data_nx[bitn] = rxs;
            bitn_nx       = bitn + 3'd1;
            if (bitn == (bit8 ? 3'd7 : 3'd6))
              state_nx = parity_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (baud_en) begin
          cnt_nx = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            // data[7] is still zero in 7-bit mode, so the full-byte XOR is exact.
            perr_nx  = (rxs != parity_bit(odd_n_even, data));
            state_nx = STOP;
          end
        end
      end
      STOP: begin
        if (baud_en) begin
          cnt_nx = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            load     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters, shift register and parity result.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt  <= '0;
      bitn <= '0;
      data <= '0;
      perr <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      bitn <= bitn_nx;
      data <= data_nx;
      perr <= perr_nx;
    end
  end

  // Host-facing registers: load beats a simultaneous read, and a read in the
  // load cycle suppresses overflow.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      host.rx_byte     <= '0;
      host.rx_rdy      <= 1'b0;
      host.parity_err  <= 1'b0;
      host.framing_err <= 1'b0;
      host.overflow    <= 1'b0;
      host.fifo_write  <= 1'b0;
    end else begin
      host.fifo_write <= load;
      if (load) begin
        host.rx_byte     <= data;
        host.parity_err  <= perr & parity_en;
        host.framing_err <= ~rxs;
        host.rx_rdy      <= 1'b1;
        host.overflow    <= ~host.read_rx_byte & (host.overflow | host.rx_rdy);
      end else if (host.read_rx_byte) begin
        host.rx_rdy   <= 1'b0;
        host.overflow <= 1'b0;
      end
    end
  end

endmodule
